deserializer: RTL and testbench

- Receive-side counterpart of the serializer.
- Collects a bit stream (qbit qualified by qbiten, MSB first) into L-bit words.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface to the downstream consumer (e.g. the Toeplitz hashing stage).
- Provides word alignment, an overrun flag and a received-word counter.

---
 rtl/deserializer.sv | 113 +++++++++++
 tb/tb_deserializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects MSB-first bits into L-bit words and
// queues completed words in a small FIFO with a valid/ready output.
module deserializer #(
    parameter int L     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 qbit,
    input  logic                 qbiten,
    input  logic                 align,
    output logic [L-1:0]         q,
    output logic                 qvalid,
    input  logic                 qready,
    output logic [$clog2(L)-1:0] bitcnt,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic [CW-1:0]        words
);

    localparam int BW = $clog2(L);
    localparam int AW = $clog2(DEPTH);

    // Only L-1 bits are stored; the final bit of a word goes straight into the push.
    logic [L-2:0]  sr_q, sr_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [L-1:0]  mem_q [DEPTH];
    logic [L-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          qvalid_q, qvalid_d;
    logic          overrun_q, overrun_d;
    logic [CW-1:0] words_q, words_d;

    logic [L-1:0]  word;
    logic          push_w, push, pop, drop, full;

    always_comb begin
        word   = {sr_q, qbit};
        full   = (count_q == (AW+1)'(DEPTH));
        pop    = qvalid_q && qready;
        push_w = qbiten && !align && (bitcnt_q == BW'(L-1));
        push   = push_w && (!full || pop);
        drop   = push_w && full && !pop;

        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        if (align) begin
            sr_d     = '0;
            bitcnt_d = '0;
            if (qbiten) begin
                sr_d[0]  = qbit;
                bitcnt_d = BW'(1);
            end
        end else if (qbiten) begin
            sr_d     = (L-1)'({sr_q, qbit});
            bitcnt_d = push_w ? '0 : bitcnt_q + BW'(1);
        end

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = word;
            wptr_d        = wptr_q + AW'(1);
        end
        if (pop) rptr_d = rptr_q + AW'(1);

        count_d = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push && pop) count_d = count_q - (AW+1)'(1);
        qvalid_d = (count_d != '0);

        // A drop on the same edge as a clear leaves the flag set.
        overrun_d = overrun_q;
        if (drop)         overrun_d = 1'b1;
        else if (ovr_clr) overrun_d = 1'b0;

        words_d = push ? words_q + CW'(1) : words_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q      <= '0;
            bitcnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            qvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            words_q   <= '0;
        end else begin
            sr_q      <= sr_d;
            bitcnt_q  <= bitcnt_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            qvalid_q  <= qvalid_d;
            overrun_q <= overrun_d;
            words_q   <= words_d;
        end
    end

    assign q       = mem_q[rptr_q];
    assign qvalid  = qvalid_q;
    assign bitcnt  = bitcnt_q;
    assign overrun = overrun_q;
    assign words   = words_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_deserializer;
    localparam int L = 8, DEPTH = 2, CW = 16;

    logic          clk = 0, reset_n = 0;
    logic          qbit = 0, qbiten = 0, align = 0, qready = 0, ovr_clr = 0;
    logic [L-1:0]  q;
    logic          qvalid, overrun;
    logic [2:0]    bitcnt;
    logic [CW-1:0] words;

    int nchk = 0, nerr = 0;

    deserializer #(.L(L), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .qbit(qbit), .qbiten(qbiten), .align(align),
        .q(q), .qvalid(qvalid), .qready(qready), .bitcnt(bitcnt),
        .overrun(overrun), .ovr_clr(ovr_clr), .words(words)
    );

    always #5 clk = ~clk;

    // Reference model: pending bits as a list, FIFO as a bounded queue.
    bit            m_bits[$];
    logic [L-1:0]  m_fifo[$];
    logic          m_ovr = 0;
    logic [CW-1:0] m_words = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_bits.delete();
            m_fifo.delete();
            m_ovr   = 0;
            m_words = 0;
        end else begin
            logic [L-1:0] w;
            bit popped, complete;
            popped   = (m_fifo.size() > 0) && qready;
            complete = qbiten && !align && (m_bits.size() == L-1);
            w = 0;
            if (complete) begin
                foreach (m_bits[i]) w = (w << 1) | L'(m_bits[i]);
                w = (w << 1) | L'(qbit);
            end
            if (popped) void'(m_fifo.pop_front());
            if (complete) begin
                if (m_fifo.size() < DEPTH) begin
                    m_fifo.push_back(w);
                    m_words = m_words + 1'b1;
                end else m_ovr = 1;
            end else if (ovr_clr) m_ovr = 0;
            if (complete && m_ovr == 1 && ovr_clr) m_ovr = (m_fifo.size() >= DEPTH && !popped) ? 1 : m_ovr;
            if (align) begin
                m_bits.delete();
                if (qbiten) m_bits.push_back(qbit);
            end else if (qbiten) begin
                if (complete) m_bits.delete();
                else m_bits.push_back(qbit);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_qvalid", 32'(qvalid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) chk("m_q", 32'(q), 32'(m_fifo[0]));
        chk("m_bitcnt", 32'(bitcnt), 32'(m_bits.size()));
        chk("m_overrun", 32'(overrun), 32'(m_ovr));
        chk("m_words", 32'(words), 32'(m_words));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b);
        qbit = b; qbiten = 1; tick(); qbiten = 0;
    endtask

    task automatic send_word(input logic [L-1:0] w, input int maxgap);
        for (int i = L-1; i >= 0; i--) begin
            send_bit(w[i]);
            if (maxgap > 0 && i > 0) repeat ($urandom_range(maxgap, 0)) tick();
        end
    endtask

    task automatic do_reset();
        reset_n = 0; tick(); reset_n = 1; tick();
    endtask

    initial begin
        logic [L-1:0] w69;
        w69 = 8'h69;
        tick(); tick();
        chk("rst_qvalid", 32'(qvalid), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_words", 32'(words), 0);
        reset_n = 1; tick();

        // 1: back-to-back bits
        qready = 1;
        for (int i = L-1; i >= 0; i--) begin
            send_bit(w69[i]);
            chk("t1_bitcnt", 32'(bitcnt), 32'((L - i) % L));
        end
        chk("t1_qvalid", 32'(qvalid), 1);
        chk("t1_q", 32'(q), 32'h69);
        chk("t1_words", 32'(words), 1);

        // 2: gaps between bits, qvalid pulses one cycle
        do_reset();
        send_word(8'h69, 3);
        chk("t2_q", 32'(q), 32'h69);
        chk("t2_qvalid", 32'(qvalid), 1);
        tick();
        chk("t2_qvalid_fall", 32'(qvalid), 0);
        chk("t2_words", 32'(words), 1);

        // 3: overrun with stalled consumer
        do_reset();
        qready = 0;
        send_word(8'h69, 0); send_word(8'hA5, 0); send_word(8'h3C, 0);
        chk("t3_q", 32'(q), 32'h69);
        chk("t3_overrun", 32'(overrun), 1);
        chk("t3_words", 32'(words), 2);
        qready = 1; tick();
        chk("t3_q2", 32'(q), 32'hA5);
        tick();
        chk("t3_empty", 32'(qvalid), 0);
        qready = 0; ovr_clr = 1; tick(); ovr_clr = 0;
        chk("t3_ovr_clr", 32'(overrun), 0);

        // 4: push and pop on the same edge while full
        do_reset();
        send_word(8'h69, 0); send_word(8'hA5, 0);
        for (int i = L-1; i >= 1; i--) send_bit(w69[i] ^ 1'b0 ? 1'b0 : 1'b0);
        do_reset();
        send_word(8'h69, 0); send_word(8'hA5, 0);
        begin
            logic [L-1:0] w3c;
            w3c = 8'h3C;
            for (int i = L-1; i >= 1; i--) send_bit(w3c[i]);
            qready = 1;
            send_bit(w3c[0]);
        end
        chk("t4_q", 32'(q), 32'hA5);
        chk("t4_overrun", 32'(overrun), 0);
        chk("t4_words", 32'(words), 3);
        tick();
        chk("t4_q3", 32'(q), 32'h3C);
        tick();
        chk("t4_empty", 32'(qvalid), 0);

        // 5: align with a bit on the same edge
        do_reset();
        send_bit(1); send_bit(0); send_bit(1);
        align = 1; send_bit(0); align = 0;
        chk("t5_bitcnt", 32'(bitcnt), 1);
        chk("t5_noword", 32'(qvalid), 0);
        for (int i = L-2; i >= 0; i--) send_bit(w69[i]);
        chk("t5_q", 32'(q), 32'h69);
        chk("t5_words", 32'(words), 1);

        // 6: asynchronous reset mid-word with buffered data and overrun set
        do_reset();
        qready = 0;
        send_word(8'h69, 0); send_word(8'hA5, 0); send_word(8'h3C, 0);
        for (int i = 0; i < 5; i++) send_bit(1);
        #2 reset_n = 0;
        #1;
        chk("t6_qvalid", 32'(qvalid), 0);
        chk("t6_bitcnt", 32'(bitcnt), 0);
        chk("t6_words", 32'(words), 0);
        chk("t6_overrun", 32'(overrun), 0);
        @(posedge clk); #1 reset_n = 1;
        qready = 1;
        send_word(8'hA5, 0);
        chk("t6_q", 32'(q), 32'hA5);
        chk("t6_words2", 32'(words), 1);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
